// File: rtl/bnn_host_loader_if.sv
// ---------------------------------------------------------------------------
// bnn_host_loader_if
// Bundles the command/response byte streams and the classifier-side load
// interface of the BNN host loader.
//   master : the loader (drives cmd_ready, rsp_*, image, image_in_valid,
//            kernel_layer, offset_layer, class_out_ready, bad_hdr)
//   slave  : host + classifier side (drives cmd_*, rsp_ready,
//            image_in_ready, class_out, class_out_valid)
// Parameter IMG_DIM: image side length; image is [0:IMG_DIM-1][0:IMG_DIM-1].
// ---------------------------------------------------------------------------
interface bnn_host_loader_if #(
  parameter int IMG_DIM = 28
);
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       image [0:IMG_DIM-1][0:IMG_DIM-1];
  logic       image_in_valid;
  logic       image_in_ready;
  logic [1:0] kernel_layer;
  logic [1:0] offset_layer;
  logic [3:0] class_out;
  logic       class_out_valid;
  logic       class_out_ready;
  logic       bad_hdr;

  modport master (
    input  cmd_data, cmd_valid, rsp_ready, image_in_ready,
           class_out, class_out_valid,
    output cmd_ready, rsp_data, rsp_valid, image, image_in_valid,
           kernel_layer, offset_layer, class_out_ready, bad_hdr
  );

  modport slave (
    output cmd_data, cmd_valid, rsp_ready, image_in_ready,
           class_out, class_out_valid,
    input  cmd_ready, rsp_data, rsp_valid, image, image_in_valid,
           kernel_layer, offset_layer, class_out_ready, bad_hdr
  );
endinterface

// File: rtl/bnn_host_loader.sv
// ---------------------------------------------------------------------------
// bnn_host_loader
// Host-side driver for the BNN MNIST classifier. Turns a byte command stream
// into the classifier load protocol (image bus used as parameter carrier plus
// one-cycle kernel_layer/offset_layer strobes), streams a packed image in,
// hands it over, waits for the class and returns {4'hA, class} as a response.
//
// Ports:
//   clk  - single clock, posedge
//   rst  - synchronous active-high reset
//   bus  - bnn_host_loader_if.master (command/response streams, image bus,
//          image handoff, parameter strobes, class result, sticky bad_hdr)
//
// Header byte: op = [7:6] (0 nop, 1 kernel, 2 offset, 3 image),
//              layer = [5:4], [3:0] ignored.
//
// Optional feature macro: LOADER_TIMEOUT_EN
//   defined   - WAIT_CLASS watchdog; after TIMEOUT_CYC cycles without
//               class_out_valid the response byte is 8'hEF.
//   undefined - WAIT_CLASS waits indefinitely.
// ---------------------------------------------------------------------------
module bnn_host_loader #(
  parameter int IMG_DIM = 28
`ifdef LOADER_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 100000
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  bnn_host_loader_if.master     bus
);

  localparam int IMG_BITS  = IMG_DIM * IMG_DIM;
  localparam int IMG_BYTES = IMG_BITS / 8;
  localparam int CNT_W     = $clog2(IMG_BYTES);
  localparam int IDX_W     = $clog2(IMG_BITS);

  localparam logic [1:0] OP_KERNEL = 2'd1;
  localparam logic [1:0] OP_OFFSET = 2'd2;
  localparam logic [1:0] OP_IMAGE  = 2'd3;

  typedef enum logic [2:0] {
    S_HDR, S_PAYLOAD, S_ISSUE, S_IMG_PAYLOAD, S_IMG_SEND, S_WAIT_CLASS, S_RESP
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     byte_cnt;
  logic [1:0]           op_q, layer_q;
  logic [IMG_BITS-1:0]  img_q, param_img;
  logic                 cmd_ready_q, rsp_valid_q, img_valid_q, cls_ready_q, bad_hdr_q;
  logic [7:0]           rsp_data_q;
  logic [1:0]           kernel_q, offset_q;
  logic [5:0]           addr_a_q;
  logic [9:0]           addr_b_q;
  logic [23:0]          data_q;
  logic [24:0]          data25;
  logic [IDX_W-1:0]     bit_base;
  logic                 cmd_fire;
`ifdef LOADER_TIMEOUT_EN
  logic [31:0]          wait_cnt;
`endif

  assign cmd_fire = bus.cmd_valid & cmd_ready_q;
  // Data bit 24 lives in the last payload byte, used straight off the bus.
  assign data25   = {bus.cmd_data[0], data_q};
  assign bit_base = IDX_W'({byte_cnt, 3'b000});

  // NOTE: the payload fields carry no reset; every field is rewritten by
  // each 7-byte command before ISSUE reads it, and byte_cnt restarts in HDR,
  // so a reset mid-command can never surface stale bytes.
  always_ff @(posedge clk) begin
    if (state_q == S_PAYLOAD && cmd_fire) begin
      case (byte_cnt)
        CNT_W'(0): addr_a_q        <= bus.cmd_data[5:0];
        CNT_W'(1): addr_b_q[7:0]   <= bus.cmd_data;
        CNT_W'(2): addr_b_q[9:8]   <= bus.cmd_data[1:0];
        CNT_W'(3): data_q[7:0]     <= bus.cmd_data;
        CNT_W'(4): data_q[15:8]    <= bus.cmd_data;
        CNT_W'(5): data_q[23:16]   <= bus.cmd_data;
        default: ;
      endcase
    end
  end

  // Parameter image for the ISSUE cycle; row r bit j lives at r*IMG_DIM+j.
  always_comb begin
    // NOTE: default everything first so no path leaves a bit unassigned
    // (which would infer a latch) and unmapped bits are zero.
    param_img = '0;
    case ({op_q, layer_q})
      {OP_KERNEL, 2'd1}: begin
        param_img[4*IMG_DIM +: 5]  = addr_a_q[4:0];
        param_img[5*IMG_DIM +: 3]  = addr_b_q[2:0];
        param_img[0 +: 25]         = data25;
      end
      {OP_KERNEL, 2'd2}: begin
        param_img[7*IMG_DIM +: 6]  = addr_a_q;
        param_img[4*IMG_DIM +: 5]  = addr_b_q[4:0];
        param_img[0 +: 25]         = data25;
      end
      {OP_KERNEL, 2'd3}: begin
        param_img[6*IMG_DIM +: 4]  = addr_a_q[3:0];
        param_img[8*IMG_DIM +: 10] = addr_b_q;
        param_img[3*IMG_DIM]       = data25[0];
      end
      {OP_OFFSET, 2'd1}: begin
        param_img[4*IMG_DIM +: 5]  = addr_a_q[4:0];
        param_img[3*IMG_DIM +: 7]  = data25[6:0];
      end
      {OP_OFFSET, 2'd2}: begin
        param_img[7*IMG_DIM +: 6]  = addr_a_q;
        param_img[3*IMG_DIM +: 9]  = data25[8:0];
      end
      {OP_OFFSET, 2'd3}: begin
        param_img[6*IMG_DIM +: 4]  = addr_a_q[3:0];
        param_img[3*IMG_DIM +: 8]  = data25[7:0];
      end
      default: ;
    endcase
  end

  // NOTE: every flop below uses non-blocking (<=) so all branches see the
  // pre-edge state and the order of statements cannot change behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HDR;
      byte_cnt    <= '0;
      op_q        <= '0;
      layer_q     <= '0;
      img_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      img_valid_q <= 1'b0;
      cls_ready_q <= 1'b0;
      kernel_q    <= '0;
      offset_q    <= '0;
      bad_hdr_q   <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      case (state_q)
        S_HDR: begin
          cmd_ready_q <= 1'b1;
          if (cmd_fire) begin
            op_q     <= bus.cmd_data[7:6];
            layer_q  <= bus.cmd_data[5:4];
            byte_cnt <= '0;
            case (bus.cmd_data[7:6])
              OP_KERNEL, OP_OFFSET: begin
                if (bus.cmd_data[5:4] == 2'd0) bad_hdr_q <= 1'b1;
                else                           state_q   <= S_PAYLOAD;
              end
              OP_IMAGE: begin
                img_q   <= '0;
                state_q <= S_IMG_PAYLOAD;
              end
              default: ;
            endcase
          end
        end
        S_PAYLOAD: begin
          if (cmd_fire) begin
            if (byte_cnt == CNT_W'(6)) begin
              // param_img already sees the last byte through data25.
              img_q       <= param_img;
              kernel_q    <= (op_q == OP_KERNEL) ? layer_q : 2'd0;
              offset_q    <= (op_q == OP_OFFSET) ? layer_q : 2'd0;
              cmd_ready_q <= 1'b0;
              state_q     <= S_ISSUE;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        S_ISSUE: begin
          kernel_q    <= '0;
          offset_q    <= '0;
          img_q       <= '0;
          cmd_ready_q <= 1'b1;
          state_q     <= S_HDR;
        end
        S_IMG_PAYLOAD: begin
          if (cmd_fire) begin
            img_q[bit_base +: 8] <= bus.cmd_data;
            if (byte_cnt == CNT_W'(IMG_BYTES - 1)) begin
              cmd_ready_q <= 1'b0;
              img_valid_q <= 1'b1;
              state_q     <= S_IMG_SEND;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        S_IMG_SEND: begin
          if (bus.image_in_ready) begin
            img_valid_q <= 1'b0;
            cls_ready_q <= 1'b1;
`ifdef LOADER_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
            state_q     <= S_WAIT_CLASS;
          end
        end
        S_WAIT_CLASS: begin
          if (bus.class_out_valid) begin
            rsp_data_q  <= {4'hA, bus.class_out};
            rsp_valid_q <= 1'b1;
            cls_ready_q <= 1'b0;
            state_q     <= S_RESP;
          end
`ifdef LOADER_TIMEOUT_EN
          else if (wait_cnt == 32'(TIMEOUT_CYC - 1)) begin
            rsp_data_q  <= 8'hEF;
            rsp_valid_q <= 1'b1;
            cls_ready_q <= 1'b0;
            state_q     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_HDR;
          end
        end
        default: state_q <= S_HDR;
      endcase
    end
  end

  assign bus.cmd_ready       = cmd_ready_q;
  assign bus.rsp_data        = rsp_data_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.image_in_valid  = img_valid_q;
  assign bus.kernel_layer    = kernel_q;
  assign bus.offset_layer    = offset_q;
  assign bus.class_out_ready = cls_ready_q;
  assign bus.bad_hdr         = bad_hdr_q;

  for (genvar r = 0; r < IMG_DIM; r++) begin : g_row
    for (genvar c = 0; c < IMG_DIM; c++) begin : g_col
      assign bus.image[r][c] = img_q[r*IMG_DIM + c];
    end
  end

endmodule

// File: doc/bnn_host_loader.md
Name: bnn_host_loader

Overview:
Host-side driver for the BNN MNIST classifier top.
- Accepts a byte-wide command stream and turns it into the classifier's load protocol: the shared 28x28 image bus is used as a parameter/address carrier, with one-cycle kernel_layer/offset_layer strobes.
- Streams a packed image in, hands it over with image_in_valid/image_in_ready, waits for class_out, and returns the class on a byte-wide response stream.
- Sits between the host/UART bridge and the classifier.

Parameters:
IMG_DIM, 28, image side length; image payload = IMG_DIM*IMG_DIM/8 = 98 bytes
TIMEOUT_CYC, 100000, watchdog limit in WAIT_CLASS (only with LOADER_TIMEOUT_EN)

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  synchronous, active-high reset
cmd_data  in  8  command/payload byte
cmd_valid  in  1  cmd_data valid
cmd_ready  out  1  loader accepts byte this cycle
rsp_data  out  8  response byte
rsp_valid  out  1  rsp_data valid
rsp_ready  in  1  host accepts response
image  out  1 x [0:27][0:27]  unpacked bus to classifier image input
image_in_valid  out  1  image handoff valid
image_in_ready  in  1  classifier accepts image
kernel_layer  out  2  1-cycle strobe: 1=conv1, 2=conv2, 3=fc binary weight
offset_layer  out  2  1-cycle strobe: 1=conv1 bias, 2=conv2 bias, 3=fc mult
class_out  in  4  classifier result
class_out_valid  in  1  result valid
class_out_ready  out  1  loader accepts result
bad_hdr  out  1  sticky: illegal header received

Behaviour:
- Reset: all outputs 0, image all 0, FSM in HDR, byte counter 0. Reset mid-command drops partial payload; no strobe may issue afterward.
- Byte transfer occurs when cmd_valid & cmd_ready. cmd_ready=1 only in HDR, PAYLOAD, IMG_PAYLOAD.
- Header byte fields: op = [7:6], layer = [5:4], [3:0] ignored.
- op 0 is NOP; stay in HDR.
- op 1 (kernel) / op 2 (offset) with layer=0: set bad_hdr and stay in HDR.
- op 1 / op 2 with layer 1..3 go to PAYLOAD: 7 bytes. B0=addr_a, {B2,B1}=addr_b[15:0], {B6..B3}=data[31:0], little-endian.
- op 3 goes to IMG_PAYLOAD; the layer field is ignored.
- After byte 7, go to ISSUE for exactly 1 cycle. The image bus holds the mapped fields; all other bits are 0. The matching strobe = layer in the same cycle; then return to HDR. Row r bit j means image[r][j] = field bit j.
  - kernel L1: row4[4:0]=addr_a, row5[2:0]=addr_b, row0[i]=data[i] for i 0..24
  - kernel L2: row7[5:0]=addr_a, row4[4:0]=addr_b, row0 as L1
  - kernel L3: row6[3:0]=addr_a, row8[9:0]=addr_b, row3[0]=data[0]
  - offset L1: row4[4:0]=addr_a, row3[6:0]=data
  - offset L2: row7[5:0]=addr_a, row3[8:0]=data
  - offset L3: row6[3:0]=addr_a, row3[7:0]=data
  - Unused high address/data bits are ignored.
- IMG_PAYLOAD: 98 bytes. Byte n bit k goes to pixel p=8n+k, i.e. image[p/28][p%28]. The bus is cleared to 0 on entry. Then IMG_SEND.
- IMG_SEND: image_in_valid=1 with the bus stable until image_in_ready=1 (handoff cycle). Next cycle image_in_valid=0 and go to WAIT_CLASS. The bus keeps the image.
- WAIT_CLASS: class_out_ready=1. On class_out_valid, capture class_out and go to RESP.
- RESP: rsp_valid=1, rsp_data={4'hA, class}, held until rsp_ready; then HDR.
- kernel_layer and offset_layer are never both nonzero.
- Strobes are 0 outside ISSUE.

Optional Feature:
LOADER_TIMEOUT_EN:
- Defined: a cycle counter runs in WAIT_CLASS. At TIMEOUT_CYC cycles without class_out_valid, go to RESP with rsp_data=8'hEF.
- Undefined: WAIT_CLASS waits indefinitely; rsp_data upper nibble is always 4'hA.

Test Plan:
- Kernel L1 load: bytes 0x50, 0x11, 0x03, 0x00, 0xFF, 0xFF, 0xFF, 0x01 -> exactly one cycle with kernel_layer=1, image[4][4:0]=5'h11, image[5][2:0]=3, row0[0:24] all 1, all other bits 0; cmd_ready low that cycle.
- Offset L2 load: header 0xA0, addr_a=0x2B, data=0x1A5 -> one cycle with offset_layer=2, image[7][5:0]=0x2B, image[3][8:0]=0x1A5.
- Header 0x40 (kernel, layer 0) -> bad_hdr=1, no strobe; subsequent NOP 0x00 accepted; bad_hdr stays set until rst.
- Image 0xC0 + 98 bytes (byte0=0x01, byte97=0x80, rest 0) -> image[0][0]=1 and image[27][27]=1 only. image_in_ready held low 5 cycles: valid stays 1, bus stable. Then class_out=7 valid -> rsp_data=0xA7, held while rsp_ready=0 for 3 cycles.
- rst asserted after 4 of 7 payload bytes -> all outputs 0; the next full command is decoded correctly with no stale bytes.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYC=50, no class_out_valid -> rsp_data=0xEF after 50 cycles in WAIT_CLASS.
